// File: rtl/hevc_ref_row_fetcher.sv
// Fetches a 15x15 reference window for the subpixel interpolator from byte-wide frame memory and
// serves it row by row. Edge-pixel replication is built when HEVC_FETCH_EDGE_CLAMP_EN is defined.
module hevc_ref_row_fetcher #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned WIN     = 15,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned CRD_W   = 12,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CRD_W-1:0]     org_x,
    input  logic [CRD_W-1:0]     org_y,
    input  logic [CRD_W-1:0]     frame_w,
    input  logic [CRD_W-1:0]     frame_h,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [PIX_W-1:0]     mem_rdata,
    input  logic [7:0]           next_row,
    output logic [WIN*PIX_W-1:0] in_row,
    output logic                 win_valid,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned CW = $clog2(WIN);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] LAST = CW'(WIN - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_READY} state_t;
    state_t state_q, state_d;

    logic [CRD_W-1:0]  ox_q, ox_d, oy_q, oy_d, fw_q, fw_d, fh_q, fh_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]     rq_row_q, rq_row_d, rq_col_q, rq_col_d;
    logic [CW-1:0]     wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [OW-1:0]     outs_q, outs_d;
    logic              done_q, done_d;
    logic [WIN*PIX_W-1:0] rows_q [WIN];

    logic [CRD_W:0]    x_raw, y_raw;
    logic [CRD_W-1:0]  xc, yc;
    logic              x_neg, x_hi, y_neg, y_hi;
    logic [ADDR_W-1:0] addr;
    logic              fetching, rsp, room, req_ok, skip, grant, issue, wr_en;
    logic [PIX_W-1:0]  wr_data;

    // One extra bit keeps the sign of origin + offset for the edge tests.
    assign x_raw = {ox_q[CRD_W-1], ox_q} + (CRD_W+1)'(rq_col_q);
    assign y_raw = {oy_q[CRD_W-1], oy_q} + (CRD_W+1)'(rq_row_q);
    assign x_neg = x_raw[CRD_W];
    assign y_neg = y_raw[CRD_W];
    assign x_hi  = !x_neg && (x_raw[CRD_W-1:0] >= fw_q);
    assign y_hi  = !y_neg && (y_raw[CRD_W-1:0] >= fh_q);
    assign xc    = x_neg ? '0 : (x_hi ? fw_q - 1'b1 : x_raw[CRD_W-1:0]);
    assign yc    = y_neg ? '0 : (y_hi ? fh_q - 1'b1 : y_raw[CRD_W-1:0]);
    assign addr  = base_q + ADDR_W'(yc) * ADDR_W'(fw_q) + ADDR_W'(xc);

    assign fetching = (state_q == S_FETCH);
    assign rsp      = mem_rvalid && (state_q == S_FETCH || state_q == S_DRAIN);
    assign room     = (outs_q < OW'(MAX_OUT)) || rsp;

`ifdef HEVC_FETCH_EDGE_CLAMP_EN
    assign req_ok = 1'b1;
    assign skip   = 1'b0;
`else
    // An out-of-frame pixel waits until nothing is in flight so its zero lands in raster order.
    assign req_ok = !(x_neg || x_hi || y_neg || y_hi);
    assign skip   = fetching && !req_ok && (outs_q == '0);
`endif

    assign mem_rd_en = fetching && req_ok && room;
    assign mem_addr  = fetching ? addr : '0;
    assign grant     = mem_rd_en && mem_gnt;
    assign issue     = grant || skip;
    assign wr_en     = rsp || skip;
    assign wr_data   = rsp ? mem_rdata : '0;

    assign win_valid = (state_q == S_READY);
    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done      = done_q;
    assign in_row    = (next_row < 8'(WIN)) ? rows_q[next_row[CW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ox_q     <= '0;
            oy_q     <= '0;
            fw_q     <= '0;
            fh_q     <= '0;
            base_q   <= '0;
            rq_row_q <= '0;
            rq_col_q <= '0;
            wr_row_q <= '0;
            wr_col_q <= '0;
            outs_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            fw_q     <= fw_d;
            fh_q     <= fh_d;
            base_q   <= base_d;
            rq_row_q <= rq_row_d;
            rq_col_q <= rq_col_d;
            wr_row_q <= wr_row_d;
            wr_col_q <= wr_col_d;
            outs_q   <= outs_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows_q[wr_row_q][32'(wr_col_q) * PIX_W +: PIX_W] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        fw_d     = fw_q;
        fh_d     = fh_q;
        base_d   = base_q;
        rq_row_d = rq_row_q;
        rq_col_d = rq_col_q;
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        done_d   = 1'b0;
        outs_d   = outs_q + OW'(grant) - OW'(rsp);

        if (start && (state_q == S_IDLE || state_q == S_READY)) begin
            ox_d     = org_x;
            oy_d     = org_y;
            fw_d     = frame_w;
            fh_d     = frame_h;
            base_d   = base_addr;
            rq_row_d = '0;
            rq_col_d = '0;
            wr_row_d = '0;
            wr_col_d = '0;
            state_d  = S_FETCH;
        end

        if (issue) begin
            if (rq_col_q == LAST) begin
                rq_col_d = '0;
                rq_row_d = rq_row_q + 1'b1;
                if (rq_row_q == LAST) state_d = S_DRAIN;
            end else begin
                rq_col_d = rq_col_q + 1'b1;
            end
        end

        // Last write wins over last issue so a final zero-fill goes straight to READY.
        if (wr_en) begin
            if (wr_col_q == LAST) begin
                wr_col_d = '0;
                wr_row_d = wr_row_q + 1'b1;
                if (wr_row_q == LAST) begin
                    state_d = S_READY;
                    done_d  = 1'b1;
                end
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hevc_ref_row_fetcher.sv
// Randomized bench for hevc_ref_row_fetcher: a queue-based memory responder plus a pixel-level
// reference model of the padded window.
`timescale 1ns/1ps
module tb_hevc_ref_row_fetcher;
    localparam int PIX_W = 8, WIN = 15, ADDR_W = 20, CRD_W = 12, MAX_OUT = 4;
    localparam int VW = WIN * PIX_W;
    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1, start = 1'b0;
    logic [CRD_W-1:0]  org_x = '0, org_y = '0, frame_w = '0, frame_h = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              mem_rd_en, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;
    logic [7:0]        next_row = '0;
    logic [VW-1:0]     in_row;
    logic              win_valid, busy, done;

    hevc_ref_row_fetcher #(.PIX_W(PIX_W), .WIN(WIN), .ADDR_W(ADDR_W), .CRD_W(CRD_W),
                           .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .start(start), .org_x(org_x), .org_y(org_y),
        .frame_w(frame_w), .frame_h(frame_h), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .next_row(next_row),
        .in_row(in_row), .win_valid(win_valid), .busy(busy), .done(done)
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory and window reference state
    typedef struct { int addr; int due; } rsp_t;
    rsp_t       pq[$];
    int         cyc = 0, lat = 1, stray = 0;
    bit         gnt_rand = 1'b0, flush_req = 1'b0;
    logic [7:0] mseed = '0;
    int         e_ox, e_oy, e_fw, e_fh, e_base, c0;

    function automatic logic [PIX_W-1:0] memval(input int a);
        logic [7:0] lo;
        lo = a[7:0];
        return lo ^ mseed;
    endfunction

    function automatic logic [PIX_W-1:0] exp_pix(input int r, input int c);
        int x, y, a;
        x = e_ox + c;
        y = e_oy + r;
`ifdef HEVC_FETCH_EDGE_CLAMP_EN
        if (x < 0) x = 0; else if (x > e_fw - 1) x = e_fw - 1;
        if (y < 0) y = 0; else if (y > e_fh - 1) y = e_fh - 1;
`else
        if (x < 0 || x >= e_fw || y < 0 || y >= e_fh) return '0;
`endif
        a = (e_base + y * e_fw + x) & ((1 << ADDR_W) - 1);
        return memval(a);
    endfunction

    function automatic vec_t exp_row(input int r);
        vec_t v;
        v = '0;
        if (r < WIN) for (int c = 0; c < WIN; c++) v[c*PIX_W +: PIX_W] = exp_pix(r, c);
        return v;
    endfunction

    initial begin : mem_model
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            mem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (stray > 0) begin
                stray--;
                mem_rvalid = 1'b1;
                mem_rdata  = 8'($urandom);
            end else if (pq.size() > 0 && pq[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memval(pq[0].addr);
                pq.delete(0);
            end
            @(negedge clk);
            if (flush_req) begin
                pq.delete();
                stray     = 3;
                flush_req = 1'b0;
            end else if (mem_rd_en && mem_gnt) begin
                pq.push_back('{int'(mem_addr), cyc + lat});
                check("outstanding_le_max", vec_t'(pq.size() <= MAX_OUT), vec_t'(1));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic pulse_start(input int ox, input int oy, input int fw, input int fh, input int base);
        org_x = CRD_W'(ox); org_y = CRD_W'(oy);
        frame_w = CRD_W'(fw); frame_h = CRD_W'(fh);
        base_addr = ADDR_W'(base);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic launch(input int ox, input int oy, input int fw, input int fh, input int base);
        e_ox = ox; e_oy = oy; e_fw = fw; e_fh = fh; e_base = base;
        mseed = 8'($urandom);
        c0 = cyc;
        pulse_start(ox, oy, fw, fh, base);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int t;
        t = 0;
        while (t < 6000) begin
            @(negedge clk);
            if (done) break;
            t++;
        end
        check({tag, "_done_seen"}, vec_t'(done), vec_t'(1));
        if (exp_lat >= 0) check({tag, "_latency"}, vec_t'(cyc - c0), vec_t'(exp_lat));
        check({tag, "_win_valid"}, vec_t'(win_valid), vec_t'(1));
        check({tag, "_busy_low"}, vec_t'(busy), vec_t'(0));
        @(negedge clk);
        check({tag, "_done_pulse"}, vec_t'(done), vec_t'(0));
        check({tag, "_win_hold"}, vec_t'(win_valid), vec_t'(1));
    endtask

    task automatic check_window(input string tag);
        for (int r = 0; r <= WIN + 1; r++) begin
            tick();
            next_row = 8'(r);
            @(negedge clk);
            check($sformatf("%s_row%0d", tag, r), in_row, exp_row(r));
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int fw, fh, ox, oy;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rd_en", vec_t'(mem_rd_en), vec_t'(0));
        check("rst_addr", vec_t'(mem_addr), vec_t'(0));
        check("rst_win_valid", vec_t'(win_valid), vec_t'(0));
        check("rst_busy", vec_t'(busy), vec_t'(0));
        check("rst_done", vec_t'(done), vec_t'(0));
        tick();
        rst = 1'b0;
        tick();

        // Interior window, full throughput
        launch(10, 20, 64, 64, 0);
        wait_done("interior", 227);
        check_window("interior");

        // Top-left corner
        launch(-3, -3, 64, 64, 0);
`ifdef HEVC_FETCH_EDGE_CLAMP_EN
        wait_done("corner", 227);
`else
        wait_done("corner", -1);
`endif
        check_window("corner");

        // Backpressure with longer read latency
        gnt_rand = 1'b1; lat = 3;
        launch(10, 20, 64, 64, 0);
        wait_done("backpressure", -1);
        check_window("backpressure");
        gnt_rand = 1'b0; lat = 1;

        // Start while busy is ignored, then start from READY
        launch(7, 9, 64, 64, 20'h1234);
        while (cyc < c0 + 50) tick();
        pulse_start(30, 31, 40, 40, 20'h0);
        @(negedge clk);
        check("ignored_start_busy", vec_t'(busy), vec_t'(1));
        wait_done("ignored", 227);
        check_window("ignored");
        launch(-5, 50, 60, 58, 20'hFFF00);
        @(negedge clk);
        check("ready_start_wv_drop", vec_t'(win_valid), vec_t'(0));
        check("ready_start_busy", vec_t'(busy), vec_t'(1));
        wait_done("restart", -1);
        check_window("restart");

        // Reset mid-fetch with stray responses afterwards
        launch(12, 3, 64, 64, 0);
        while (cyc < c0 + 100) tick();
        rst = 1'b1;
        flush_req = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rd_en", vec_t'(mem_rd_en), vec_t'(0));
        check("midrst_addr", vec_t'(mem_addr), vec_t'(0));
        check("midrst_win_valid", vec_t'(win_valid), vec_t'(0));
        check("midrst_busy", vec_t'(busy), vec_t'(0));
        repeat (6) tick();
        @(negedge clk);
        check("midrst_stray_busy", vec_t'(busy), vec_t'(0));
        check("midrst_stray_wv", vec_t'(win_valid), vec_t'(0));
        launch(33, 40, 80, 70, 20'h00400);
        wait_done("after_rst", 227);
        check_window("after_rst");

        // Random windows, frames and memory timing
        for (int k = 0; k < 6; k++) begin
            fw = int'($urandom_range(1, 80));
            fh = int'($urandom_range(1, 80));
            ox = int'($urandom_range(0, fw + 24)) - 12;
            oy = int'($urandom_range(0, fh + 24)) - 12;
            gnt_rand = 1'($urandom_range(0, 1));
            lat = int'($urandom_range(1, 4));
            launch(ox, oy, fw, fh, int'($urandom_range(0, (1 << ADDR_W) - 1)));
            wait_done($sformatf("rand%0d", k), -1);
            check_window($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hevc_ref_row_fetcher.md
Name: hevc_ref_row_fetcher

Overview:
- Upstream feeder for subpixel_interpolation.
- Fetches a 15x15 integer-pixel reference window (8x8 block plus 3 pixels before and 4 after on each axis for the 8-tap filters) from a byte-wide frame memory, with HEVC edge padding.
- Stores the window as 15 packed rows.
- Serves a row combinationally on in_row in response to the interpolator's next_row index.

Parameters:
- PIX_W, 8, bits per pixel.
- WIN, 15, window width and height in pixels.
- ADDR_W, 20, frame memory byte address width.
- CRD_W, 12, coordinate and frame dimension width; coordinates are signed.
- MAX_OUT, 4, maximum outstanding memory reads (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to fetch a new window; honoured only in IDLE or READY.
- org_x  in  CRD_W  signed window top-left x (block x - 3); sampled on start.
- org_y  in  CRD_W  signed window top-left y; sampled on start.
- frame_w  in  CRD_W  frame width in pixels (≥1), also the line stride; sampled on start.
- frame_h  in  CRD_W  frame height (≥1); sampled on start.
- base_addr  in  ADDR_W  address of frame pixel (0,0); sampled on start.
- mem_rd_en  out  1  read request.
- mem_addr  out  ADDR_W  read byte address.
- mem_gnt  in  1  request accepted when mem_rd_en && mem_gnt.
- mem_rvalid  in  1  read data valid; responses return in request order.
- mem_rdata  in  PIX_W  read data.
- next_row  in  8  row index requested by the interpolator.
- in_row  out  WIN*PIX_W  packed row; pixel column c occupies bits [8c+7:8c].
- win_valid  out  1  window complete and stable.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse when the window completes.

Behaviour:
- Reset clears to IDLE:
  - mem_rd_en=0, mem_addr=0, win_valid=0, busy=0, done=0.
  - Outstanding counter and request/write counters cleared.
  - Row storage is not cleared.
- States: IDLE, FETCH, DRAIN, READY.
- IDLE --start--> FETCH.
  - Latch org_x, org_y, frame_w, frame_h, base_addr.
  - Zero request counters (rq_row, rq_col) and write counters (wr_row, wr_col).
  - busy=1, win_valid=0.
- FETCH:
  - Issue requests in raster order: col 0..14 within row 0..14.
  - mem_rd_en=1 while outstanding < MAX_OUT, or while a response retires in the same cycle.
  - Request counters advance only on grant.
  - Clamped coordinates: xc = clamp(org_x+rq_col, 0, frame_w-1); yc likewise against frame_h-1.
  - mem_addr = base_addr + yc*frame_w + xc, truncated to ADDR_W.
  - mem_addr/mem_rd_en are combinational from the counters; mem_addr holds while not granted.
  - After the 225th grant -> DRAIN, mem_rd_en=0.
- Responses (FETCH or DRAIN):
  - Each mem_rvalid writes mem_rdata into row wr_row, column wr_col, then advances the write counters.
  - Outstanding count: +1 on grant, -1 on rvalid; both in one cycle leaves it unchanged.
- DRAIN: when the 225th response is written -> READY. The next cycle has win_valid=1, done=1 for one cycle, busy=0.
- READY:
  - Window held.
  - start -> FETCH exactly as from IDLE; win_valid drops the cycle after start.
- in_row:
  - Combinational: rows[next_row] for next_row<15, else all zeros.
  - Valid data is guaranteed only while win_valid=1.
- Ignored events:
  - start while busy is ignored; no effect on latched inputs.
  - mem_rvalid in IDLE or READY is ignored.
  - Reset mid-fetch abandons the fetch; responses still in flight after reset are ignored.
- Latency, with mem_gnt tied to 1 and rvalid exactly one cycle after grant:
  - start in cycle 0, requests in cycles 1..225.
  - done and win_valid high in cycle 227.

Optional Feature:
- Macro HEVC_FETCH_EDGE_CLAMP_EN.
- Defined: out-of-frame coordinates are clamped to the nearest edge pixel, as described above (HEVC reference padding).
- Undefined:
  - Out-of-frame positions issue no memory request.
  - Their pixels are written as 0 in raster order; response order is preserved.
  - Fully in-frame windows behave identically to the defined case.

Test Plan:
- Interior window:
  - Stimulus: frame 64x64, mem[a]=a[7:0], base 0, org (10,20), gnt=1, 1-cycle rvalid.
  - Response: row r, column c = ((20+r)*64+10+c)&FF; done in cycle 227; win_valid=1 afterwards.
- Top-left corner:
  - Stimulus: org (-3,-3), frame 64x64.
  - Response with clamp: rows 0..3 all equal; columns 0..3 of each row equal the pixel at x=0.
  - Response without clamp: rows 0..2 are 0.
- Backpressure and limit:
  - Stimulus: mem_gnt randomly 50%, rvalid latency 3 cycles, MAX_OUT=4.
  - Response: outstanding never exceeds 4; window contents identical to the interior case.
- Ignored start:
  - Stimulus: start pulsed again in cycle 50 with a different org.
  - Response: ignored; original window completes.
  - Then start in READY: win_valid drops next cycle; new window fetched.
- Reset mid-fetch:
  - Stimulus: rst in cycle 100, then rvalid pulses in cycles 101..103.
  - Response: IDLE; mem_rd_en=0, win_valid=0, busy=0; stray responses ignored.
  - A new fetch afterwards produces correct data.
- Row select:
  - Stimulus: next_row swept 0..16 while in READY.
  - Response: in_row equals stored rows 0..14; next_row 15 and 16 return 0.
